// File: rtl/eth_tx_payload_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : eth_tx_payload_buf
//  Purpose  : Packet-commit payload buffer ahead of the 10G Ethernet TX top.
//             Stores whole packets in a RAM FIFO, hands each committed packet
//             to the top via tx_start/data_length/tx_idle, serves its reads,
//             and drops oversize packets atomically.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_tx_payload_buf #(
    parameter int DEPTH     = 512,
    parameter int LEN_DEPTH = 16,
    parameter int MAX_BYTES = 1472
) (
    input  logic        clk_156_25,
    input  logic        rst,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic [3:0]  s_bytes,
    output logic        s_ready,
    output logic        tx_start,
    input  logic        tx_idle,
    output logic [15:0] data_length,
    input  logic        rd_req,
    output logic [63:0] rd_data,
    output logic [15:0] pkt_count,
    output logic        drop_pulse,
    output logic        len_err_pulse,
    output logic        underflow_err
);

    localparam int              C_AW        = $clog2(DEPTH);
    localparam int              C_LAW       = $clog2(LEN_DEPTH);
    localparam logic [C_AW:0]   C_DEPTH     = (C_AW + 1)'(DEPTH);
    localparam logic [C_LAW:0]  C_LEN_DEPTH = (C_LAW + 1)'(LEN_DEPTH);
    localparam logic [16:0]     C_MAX_BYTES = 17'(MAX_BYTES);

    typedef enum logic [0:0] {
        W_ACCEPT  = 1'b0,
        W_DISCARD = 1'b1
    } wstate_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_ARM  = 2'd1,
        TX_BUSY = 2'd2,
        TX_DONE = 2'd3
    } txstate_t;

    // Storage: payload words and per-packet byte lengths
    logic [63:0] mem     [DEPTH];
    logic [15:0] len_mem [LEN_DEPTH];

    wstate_t       wstate_q, wstate_d;
    txstate_t      tx_state_q, tx_state_d;
    logic [C_AW:0] wr_ptr_q, wr_ptr_d;
    logic [C_AW:0] commit_ptr_q, commit_ptr_d;
    logic [C_AW:0] rd_ptr_q, rd_ptr_d;
    logic [C_AW:0] pkt_start_q, pkt_start_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic [C_LAW:0] len_wr_ptr_q, len_wr_ptr_d;
    logic [C_LAW:0] len_rd_ptr_q, len_rd_ptr_d;
    logic [15:0]   data_length_q, data_length_d;
    logic [15:0]   rd_words_q, rd_words_d;
    logic [63:0]   rd_data_q, rd_data_d;
    logic [15:0]   pkt_count_q, pkt_count_d;
    logic          underflow_q, underflow_d;

    logic          mem_we;
    logic          len_push;
    logic          len_pop;
    logic [4:0]    last_bytes;
    logic [16:0]   new_cnt;
    logic [16:0]   exp_words;
    logic [C_AW:0] fill;
    logic [C_AW:0] committed;
    logic [C_LAW:0] len_count;
    logic          len_full;

    // Occupancy from pre-edge pointers; DISCARD swallows words regardless of space
    assign fill      = wr_ptr_q - rd_ptr_q;
    assign committed = commit_ptr_q - rd_ptr_q;
    assign len_count = len_wr_ptr_q - len_rd_ptr_q;
    assign len_full  = (len_count == C_LEN_DEPTH);
    assign s_ready   = ~rst & ((wstate_q == W_DISCARD) | ((fill < C_DEPTH) & ~len_full));

    assign data_length   = data_length_q;
    assign rd_data       = rd_data_q;
    assign pkt_count     = pkt_count_q;
    assign underflow_err = underflow_q;

    // Write FSM: accumulate a packet, commit it on the last word or drop it on overflow
    always_comb begin
        wstate_d     = wstate_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        mem_we       = 1'b0;
        len_push     = 1'b0;
        drop_pulse   = 1'b0;
        last_bytes   = ((s_bytes == 4'd0) || (s_bytes > 4'd8)) ? 5'd8 : {1'b0, s_bytes};
        new_cnt      = {1'b0, byte_cnt_q} + (s_last ? {12'd0, last_bytes} : 17'd8);
        case (wstate_q)
            W_ACCEPT: begin
                if (s_valid && s_ready) begin
                    if (new_cnt > C_MAX_BYTES) begin
                        // Roll back to the last commit so no partial packet is visible
                        wr_ptr_d   = commit_ptr_q;
                        byte_cnt_d = 16'd0;
                        if (s_last) begin
                            drop_pulse = 1'b1;
                        end else begin
                            wstate_d = W_DISCARD;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (s_last) begin
                            commit_ptr_d = wr_ptr_q + 1'b1;
                            len_push     = 1'b1;
                            byte_cnt_d   = 16'd0;
                        end else begin
                            byte_cnt_d = new_cnt[15:0];
                        end
                    end
                end
            end
            W_DISCARD: begin
                if (s_valid && s_last) begin
                    drop_pulse = 1'b1;
                    wstate_d   = W_ACCEPT;
                end
            end
            default: wstate_d = W_ACCEPT;
        endcase
    end

    // Read path and TX handshake FSM, including read-pointer resync on a short/long read
    always_comb begin
        tx_state_d    = tx_state_q;
        rd_ptr_d      = rd_ptr_q;
        rd_words_d    = rd_words_q;
        rd_data_d     = rd_data_q;
        underflow_d   = underflow_q;
        data_length_d = data_length_q;
        pkt_start_d   = pkt_start_q;
        pkt_count_d   = pkt_count_q;
        len_pop       = 1'b0;
        tx_start      = 1'b0;
        len_err_pulse = 1'b0;
        exp_words     = ({1'b0, data_length_q} + 17'd7) >> 3;

        if (rd_req) begin
            if (committed != '0) begin
                rd_data_d  = mem[rd_ptr_q[C_AW-1:0]];
                rd_ptr_d   = rd_ptr_q + 1'b1;
                rd_words_d = rd_words_q + 16'd1;
            end else begin
                rd_data_d   = 64'd0;
                underflow_d = 1'b1;
            end
        end

        case (tx_state_q)
            TX_IDLE: begin
                if ((len_count != '0) && tx_idle) begin
                    data_length_d = len_mem[len_rd_ptr_q[C_LAW-1:0]];
                    pkt_start_d   = rd_ptr_q;
                    tx_state_d    = TX_ARM;
                end
            end
            TX_ARM: begin
                tx_start = 1'b1;
                if (!tx_idle) begin
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_idle) begin
                    tx_state_d = TX_DONE;
                end
            end
            TX_DONE: begin
                if ({1'b0, rd_words_q} != exp_words) begin
                    len_err_pulse = 1'b1;
                    rd_ptr_d      = pkt_start_q + (C_AW + 1)'(exp_words);
                end
                len_pop     = 1'b1;
                pkt_count_d = pkt_count_q + 16'd1;
                rd_words_d  = 16'd0;
                tx_state_d  = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RAM writes (no reset: contents are meaningless until committed)
    always_ff @(posedge clk_156_25) begin
        if (mem_we) begin
            mem[wr_ptr_q[C_AW-1:0]] <= s_data;
        end
        if (len_push) begin
            len_mem[len_wr_ptr_q[C_LAW-1:0]] <= new_cnt[15:0];
        end
    end

    // State and pointer registers
    always_ff @(posedge clk_156_25 or posedge rst) begin
        if (rst) begin
            wstate_q      <= W_ACCEPT;
            tx_state_q    <= TX_IDLE;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            pkt_start_q   <= '0;
            byte_cnt_q    <= '0;
            len_wr_ptr_q  <= '0;
            len_rd_ptr_q  <= '0;
            data_length_q <= '0;
            rd_words_q    <= '0;
            rd_data_q     <= '0;
            pkt_count_q   <= '0;
            underflow_q   <= 1'b0;
        end else begin
            wstate_q      <= wstate_d;
            tx_state_q    <= tx_state_d;
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pkt_start_q   <= pkt_start_d;
            byte_cnt_q    <= byte_cnt_d;
            len_wr_ptr_q  <= len_wr_ptr_q + {{C_LAW{1'b0}}, len_push};
            len_rd_ptr_q  <= len_rd_ptr_q + {{C_LAW{1'b0}}, len_pop};
            data_length_q <= data_length_d;
            rd_words_q    <= rd_words_d;
            rd_data_q     <= rd_data_d;
            pkt_count_q   <= pkt_count_d;
            underflow_q   <= underflow_d;
        end
    end

    assign len_wr_ptr_d = len_wr_ptr_q;
    assign len_rd_ptr_d = len_rd_ptr_q;

endmodule
`default_nettype wire
